// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor computing diff = a - b - bin over WIDTH bits using a
//   single full-subtractor cell, LSB first, one bit per clock. Also reports
//   the final borrow and signed two's-complement overflow.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous, active-high reset
//   start    operation request; accepted in IDLE or DONE
//   a, b     minuend / subtrahend, sampled on the accepting edge
//   bin      borrow-in, sampled on the accepting edge
//   busy     high while bits are being processed
//   done     one-cycle pulse; diff/borrow/overflow valid
//   diff     a - b - bin modulo 2^WIDTH
//   borrow   final borrow-out (unsigned a < b + bin)
//   overflow signed overflow of the subtraction
module serial_subtractor #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             a_msb;
  logic             b_msb;
  logic             br;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             last;
  logic             bit_x;
  logic             bit_y;
  logic             bit_d;
  logic             br_nxt;
  logic             ovf_nxt;
  logic             busy_nxt;
  logic [WIDTH-1:0] res_nxt;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (cnt == CNT_W'(WIDTH - 1)) state_nxt = DONE;
      end
      DONE: begin
        // A start seen while done is pulsing is taken as a fresh request.
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Full-subtractor cell and control decode
  always_comb begin
    accept   = start && (state != RUN);
    last     = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
    bit_x    = a_sh[0];
    bit_y    = b_sh[0];
    bit_d    = bit_x ^ bit_y ^ br;
    br_nxt   = (~bit_x & bit_y) | (~(bit_x ^ bit_y) & br);
    // busy lags entry to RUN by one edge and drops on the edge that
    // processes the final bit, so it is a clean registered flag.
    busy_nxt = (state == RUN) && !last;
    ovf_nxt  = (a_msb != b_msb) && (res_nxt[WIDTH-1] != a_msb);
  end

  // Result bits enter from the MSB side so the word is aligned after WIDTH shifts.
  if (WIDTH == 1) begin : g_res_w1
    assign res_nxt = bit_d;
  end else begin : g_res_wn
    assign res_nxt = {bit_d, res_sh[WIDTH-1:1]};
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      br       <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= last;
      if (accept) begin
        a_sh   <= a;
        b_sh   <= b;
        br     <= bin;
        a_msb  <= a[WIDTH-1];
        b_msb  <= b[WIDTH-1];
        res_sh <= '0;
        cnt    <= '0;
      end else if (state == RUN) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        br     <= br_nxt;
        res_sh <= res_nxt;
        cnt    <= cnt + CNT_W'(1);
      end
      if (last) begin
        diff     <= res_nxt;
        borrow   <= br_nxt;
        overflow <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH = 8, 1 and 16.
// Expected results come from an arithmetic reference model and are queued
// when an operation is issued, then popped when the DUT pulses done.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // WIDTH = 8
  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        bin8 = 1'b0;
  logic        busy8, done8, bor8, ovf8;
  logic [7:0]  diff8;

  // WIDTH = 1
  logic        start1 = 1'b0;
  logic        a1 = 1'b0, b1 = 1'b0, bin1 = 1'b0;
  logic        busy1, done1, bor1, ovf1;
  logic        diff1;

  // WIDTH = 16
  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        bin16 = 1'b0;
  logic        busy16, done16, bor16, ovf16;
  logic [15:0] diff16;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(bor8), .overflow(ovf8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow(bor1), .overflow(ovf1)
  );

  serial_subtractor #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .bin(bin16),
    .busy(busy16), .done(done16), .diff(diff16), .borrow(bor16), .overflow(ovf16)
  );

  int unsigned tests  = 0;
  int unsigned failed = 0;

  logic [65:0] sb8[$];
  logic [65:0] sb1[$];
  logic [65:0] sb16[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {overflow, borrow, diff} for a w-bit a - b - bin.
  function automatic logic [65:0] model(input int w, input logic [63:0] a,
                                        input logic [63:0] b, input logic bin);
    logic [64:0] r;
    logic [63:0] mask;
    logic [63:0] d;
    logic        bo;
    logic        ov;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    r    = {1'b0, a & mask} - {1'b0, b & mask} - {64'd0, bin};
    d    = r[63:0] & mask;
    bo   = r[w];
    ov   = (a[w-1] != b[w-1]) && (d[w-1] != a[w-1]);
    return {ov, bo, d};
  endfunction

  function automatic logic [65:0] res_of(input int w);
    case (w)
      8:       return {ovf8, bor8, 56'd0, diff8};
      1:       return {ovf1, bor1, 63'd0, diff1};
      default: return {ovf16, bor16, 48'd0, diff16};
    endcase
  endfunction

  function automatic logic done_of(input int w);
    case (w)
      8:       return done8;
      1:       return done1;
      default: return done16;
    endcase
  endfunction

  function automatic logic busy_of(input int w);
    case (w)
      8:       return busy8;
      1:       return busy1;
      default: return busy16;
    endcase
  endfunction

  task automatic drive(input int w, input logic [63:0] a, input logic [63:0] b,
                       input logic bin, input logic st);
    case (w)
      8:       begin a8 = a[7:0];   b8 = b[7:0];   bin8 = bin;  start8 = st;  end
      1:       begin a1 = a[0];     b1 = b[0];     bin1 = bin;  start1 = st;  end
      default: begin a16 = a[15:0]; b16 = b[15:0]; bin16 = bin; start16 = st; end
    endcase
  endtask

  // Drive a request and queue its expected result.
  task automatic issue(input int w, input logic [63:0] a, input logic [63:0] b, input logic bin);
    drive(w, a, b, bin, 1'b1);
    case (w)
      8:       sb8.push_back(model(8, a, b, bin));
      1:       sb1.push_back(model(1, a, b, bin));
      default: sb16.push_back(model(16, a, b, bin));
    endcase
  endtask

  // Called on the falling edge just after the accepting edge: drop start and
  // scramble operands, which the DUT must no longer look at.
  task automatic release_start(input int w);
    drive(w, 64'($urandom) << 32 | 64'($urandom), 64'($urandom), 1'($urandom), 1'b0);
  endtask

  // Poll for done with a cycle bound, then compare latency, busy cycles and
  // the result against the scoreboard head.
  task automatic await_done(input int w, input int exp_lat, input int exp_busy, input string tag);
    int          got = 0;
    int          bc  = 0;
    logic [65:0] e;
    logic [65:0] r;
    for (int c = 1; c <= exp_lat + 4; c++) begin
      @(negedge clk);
      if (busy_of(w)) bc++;
      if (done_of(w)) begin
        got = c;
        break;
      end
    end
    chk({tag, ".latency"}, 64'(got), 64'(exp_lat));
    chk({tag, ".busy_cycles"}, 64'(bc), 64'(exp_busy));
    e = 'x;
    case (w)
      8:       if (sb8.size()  > 0) e = sb8.pop_front();
      1:       if (sb1.size()  > 0) e = sb1.pop_front();
      default: if (sb16.size() > 0) e = sb16.pop_front();
    endcase
    r = res_of(w);
    chk({tag, ".diff"}, r[63:0], e[63:0]);
    chk({tag, ".borrow"}, 64'(r[64]), 64'(e[64]));
    chk({tag, ".overflow"}, 64'(r[65]), 64'(e[65]));
  endtask

  task automatic pulse_check(input int w, input string tag);
    @(negedge clk);
    chk({tag, ".done_pulse"}, 64'(done_of(w)), 64'd0);
  endtask

  task automatic run(input int w, input logic [63:0] a, input logic [63:0] b,
                     input logic bin, input string tag);
    issue(w, a, b, bin);
    @(negedge clk);
    release_start(w);
    await_done(w, w, (w > 1) ? w - 1 : 0, tag);
    pulse_check(w, tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tdiff;
    logic [7:0] tborr;
    int         seen;
    logic [65:0] r;

    // Reset state
    repeat (3) @(negedge clk);
    r = res_of(8);
    chk("rst.w8.outputs", {busy8, done8, r[65:64], r[7:0]}, '0);
    r = res_of(1);
    chk("rst.w1.outputs", {busy1, done1, r[65:64], r[0]}, '0);
    r = res_of(16);
    chk("rst.w16.outputs", {busy16, done16, r[65:64], r[15:0]}, '0);
    rst = 1'b0;
    @(negedge clk);

    // Basic and boundary subtractions at WIDTH = 8
    run(8, 'h05, 'h03, 1'b0, "t1");
    run(8, 'h03, 'h05, 1'b0, "t2a");
    run(8, 'h00, 'h00, 1'b1, "t2b");
    run(8, 'h80, 'h01, 1'b0, "t3a");
    run(8, 'h7F, 'hFF, 1'b0, "t3b");

    // Start during RUN is ignored; start held in DONE is accepted back-to-back.
    issue(8, 'h10, 'h01, 1'b0);
    @(negedge clk);
    drive(8, 'h10, 'h01, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("t4.busy_mid_run", 64'(busy8), 64'd1);
    drive(8, 'hAA, 'h55, 1'b0, 1'b1);
    @(negedge clk);
    drive(8, 'h00, 'h00, 1'b0, 1'b0);
    await_done(8, 5, 4, "t4a");
    issue(8, 'h33, 'h11, 1'b0);
    @(negedge clk);
    release_start(8);
    await_done(8, 8, 7, "t4b");
    pulse_check(8, "t4b");

    // Reset mid-RUN aborts the operation and clears outputs immediately.
    issue(8, 'h5A, 'h21, 1'b0);
    @(negedge clk);
    release_start(8);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    r = res_of(8);
    chk("t5.busy", 64'(busy8), 64'd0);
    chk("t5.done", 64'(done8), 64'd0);
    chk("t5.diff", 64'(r[7:0]), 64'd0);
    chk("t5.borrow", 64'(r[64]), 64'd0);
    chk("t5.overflow", 64'(r[65]), 64'd0);
    sb8.delete();
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done8) seen++;
    end
    chk("t5.no_done_after_abort", 64'(seen), 64'd0);
    run(8, 'hC3, 'h3C, 1'b1, "t5.fresh");

    // WIDTH = 1 truth table in binary order of {a, b, bin}
    tdiff = 8'b1001_0110;
    tborr = 8'b1000_1110;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      run(1, 64'(v[2]), 64'(v[1]), v[0], $sformatf("t6.w1.%0d", i));
      r = res_of(1);
      chk($sformatf("t6.w1.%0d.tab_diff", i), 64'(r[0]), 64'(tdiff[i]));
      chk($sformatf("t6.w1.%0d.tab_borrow", i), 64'(r[64]), 64'(tborr[i]));
    end

    // WIDTH = 16: corner cases then a random sweep
    run(16, 'h0000, 'h0000, 1'b1, "t6.w16.zero_bin");
    run(16, 'hFFFF, 'hFFFF, 1'b0, "t6.w16.ones");
    run(16, 'h8000, 'h0001, 1'b0, "t6.w16.minneg");
    run(16, 'h7FFF, 'hFFFF, 1'b1, "t6.w16.maxpos");
    for (int n = 0; n < 1000; n++) begin
      run(16, 64'($urandom_range(16'hFFFF, 0)), 64'($urandom_range(16'hFFFF, 0)),
          1'($urandom), $sformatf("t6.w16.rnd%0d", n));
    end

    chk("end.sb8_empty", 64'(sb8.size()), 64'd0);
    chk("end.sb1_empty", 64'(sb1.size()), 64'd0);
    chk("end.sb16_empty", 64'(sb16.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
